// File: rtl/oven_countdown_timer.sv
// ---------------------------------------------------------------------------
// oven_countdown_timer
//
// Cook timer for the oven controller. Takes an MM:SS setpoint as four BCD
// digits, validates it, keeps it as binary minutes/seconds and counts down
// one second per CLK_HZ clock cycles until 00:00. The remaining time is fed
// back out as BCD digits for the 7-segment display path, and completion is
// flagged to the heater/buzzer control.
//
// Parameters
//   CLK_HZ        clock cycles per one-second tick
//
// Ports
//   clock         in   system clock, rising edge
//   reset_n       in   asynchronous, active-low reset
//   load          in   1-cycle pulse: capture set_* digits as the new setpoint
//   set_min_tens  in   BCD setpoint, minutes tens digit
//   set_min_units in   BCD setpoint, minutes units digit
//   set_sec_tens  in   BCD setpoint, seconds tens digit (0..5)
//   set_sec_units in   BCD setpoint, seconds units digit
//   start         in   1-cycle pulse: begin or resume the countdown
//   pause         in   1-cycle pulse: suspend the countdown
//   clear         in   1-cycle pulse: abort and zero the timer
//   min_tens      out  remaining minutes, tens digit (BCD)
//   min_units     out  remaining minutes, units digit (BCD)
//   sec_tens      out  remaining seconds, tens digit (BCD)
//   sec_units     out  remaining seconds, units digit (BCD)
//   running       out  high while counting down
//   done          out  level, high while the timer sits at its end state
//   done_pulse    out  1-cycle strobe on entry to the end state
//   load_err      out  1-cycle strobe: setpoint rejected
// ---------------------------------------------------------------------------
module oven_countdown_timer #(
    parameter int CLK_HZ = 50_000_000
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       load,
    input  logic [3:0] set_min_tens,
    input  logic [3:0] set_min_units,
    input  logic [3:0] set_sec_tens,
    input  logic [3:0] set_sec_units,
    input  logic       start,
    input  logic       pause,
    input  logic       clear,
    output logic [3:0] min_tens,
    output logic [3:0] min_units,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_units,
    output logic       running,
    output logic       done,
    output logic       done_pulse,
    output logic       load_err
);

    // A 1 Hz clock would give a zero-width prescaler; keep at least one bit.
    localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_HZ - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READY,
        ST_RUNNING,
        ST_PAUSED,
        ST_DONE
    } state_t;

    // -----------------------------------------------------------------------
    // Helpers
    // -----------------------------------------------------------------------
    function automatic logic [3:0] bcd_tens(input logic [6:0] v);
        logic [6:0] q;
        q = v / 7'd10;
        return q[3:0];
    endfunction

    function automatic logic [3:0] bcd_units(input logic [6:0] v);
        logic [6:0] r;
        r = v % 7'd10;
        return r[3:0];
    endfunction

    function automatic logic bcd_ok(input logic [3:0] d);
        return d <= 4'd9;
    endfunction

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    state_t         state,        state_n;
    logic [6:0]     minutes,      minutes_n;
    logic [5:0]     seconds,      seconds_n;
    logic [PW-1:0]  prescaler,    prescaler_n;
    logic           done_pulse_q, done_pulse_n;
    logic           load_err_q,   load_err_n;

    // Decoded setpoint and command qualifiers
    logic           set_valid;
    logic [6:0]     set_minutes;
    logic [5:0]     set_seconds;
    logic           load_take;
    logic           start_only;
    logic           pause_only;

    // Decremented time for the tick path
    logic [6:0]     dec_minutes;
    logic [5:0]     dec_seconds;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            minutes      <= '0;
            seconds      <= '0;
            prescaler    <= '0;
            done_pulse_q <= 1'b0;
            load_err_q   <= 1'b0;
        end else begin
            state        <= state_n;
            minutes      <= minutes_n;
            seconds      <= seconds_n;
            prescaler    <= prescaler_n;
            done_pulse_q <= done_pulse_n;
            load_err_q   <= load_err_n;
        end
    end

    // -----------------------------------------------------------------------
    // Setpoint decode
    // -----------------------------------------------------------------------
    always_comb begin
        set_valid   = bcd_ok(set_min_tens) && bcd_ok(set_min_units) &&
                      bcd_ok(set_sec_units) && (set_sec_tens <= 4'd5);
        set_minutes = ({3'b000, set_min_tens} * 7'd10) + {3'b000, set_min_units};
        set_seconds = ({2'b00, set_sec_tens} * 6'd10) + {2'b00, set_sec_units};
    end

    // -----------------------------------------------------------------------
    // One-second decrement with minute borrow
    // -----------------------------------------------------------------------
    always_comb begin
        dec_minutes = minutes;
        dec_seconds = seconds;
        if (seconds != 6'd0) begin
            dec_seconds = seconds - 6'd1;
        end else if (minutes != 7'd0) begin
            dec_minutes = minutes - 7'd1;
            dec_seconds = 6'd59;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic: clear beats load beats start/pause. A load while
    // running is dropped entirely, so start/pause and ticking carry on.
    // -----------------------------------------------------------------------
    always_comb begin
        state_n      = state;
        minutes_n    = minutes;
        seconds_n    = seconds;
        prescaler_n  = prescaler;
        done_pulse_n = 1'b0;
        load_err_n   = 1'b0;

        load_take  = load && (state != ST_RUNNING);
        // start and pause together cancel each other.
        start_only = start && !pause;
        pause_only = pause && !start;

        if (clear) begin
            state_n     = ST_IDLE;
            minutes_n   = '0;
            seconds_n   = '0;
            prescaler_n = '0;
        end else if (load_take) begin
            if (set_valid) begin
                minutes_n = set_minutes;
                seconds_n = set_seconds;
                state_n   = ((set_minutes == 7'd0) && (set_seconds == 6'd0))
                            ? ST_IDLE : ST_READY;
            end else begin
                load_err_n = 1'b1;
            end
        end else begin
            unique case (state)
                ST_READY: begin
                    if (start_only) begin
                        state_n     = ST_RUNNING;
                        prescaler_n = '0;
                    end
                end
                ST_PAUSED: begin
                    // Resume keeps the partial second already counted.
                    if (start_only) begin
                        state_n = ST_RUNNING;
                    end
                end
                ST_RUNNING: begin
                    if (pause_only) begin
                        state_n = ST_PAUSED;
                    end else if (prescaler == PRESC_MAX) begin
                        prescaler_n = '0;
                        minutes_n   = dec_minutes;
                        seconds_n   = dec_seconds;
                        if ((dec_minutes == 7'd0) && (dec_seconds == 6'd0)) begin
                            state_n      = ST_DONE;
                            done_pulse_n = 1'b1;
                        end
                    end else begin
                        prescaler_n = prescaler + PW'(1);
                    end
                end
                ST_IDLE, ST_DONE: begin
                    // start/pause have no effect here
                end
                default: begin
                    state_n = ST_IDLE;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Outputs: digits follow the time registers combinationally
    // -----------------------------------------------------------------------
    always_comb begin
        min_tens   = bcd_tens(minutes);
        min_units  = bcd_units(minutes);
        sec_tens   = bcd_tens({1'b0, seconds});
        sec_units  = bcd_units({1'b0, seconds});
        running    = (state == ST_RUNNING);
        done       = (state == ST_DONE);
        done_pulse = done_pulse_q;
        load_err   = load_err_q;
    end

endmodule

// File: tb/tb_oven_countdown_timer.sv
// ---------------------------------------------------------------------------
// tb_oven_countdown_timer
//
// Directed bench for oven_countdown_timer with a 4-cycle second. Inputs are
// driven and outputs sampled on the falling clock edge; each scenario task
// carries its own hand-computed expectations.
// ---------------------------------------------------------------------------
module tb_oven_countdown_timer;

    logic       clock;
    logic       reset_n;
    logic       load;
    logic [3:0] set_min_tens, set_min_units, set_sec_tens, set_sec_units;
    logic       start, pause, clear;
    logic [3:0] min_tens, min_units, sec_tens, sec_units;
    logic       running, done, done_pulse, load_err;

    int checks   = 0;
    int failures = 0;

    logic [15:0] digits;
    assign digits = {min_tens, min_units, sec_tens, sec_units};

    oven_countdown_timer #(.CLK_HZ(4)) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .load          (load),
        .set_min_tens  (set_min_tens),
        .set_min_units (set_min_units),
        .set_sec_tens  (set_sec_tens),
        .set_sec_units (set_sec_units),
        .start         (start),
        .pause         (pause),
        .clear         (clear),
        .min_tens      (min_tens),
        .min_units     (min_units),
        .sec_tens      (sec_tens),
        .sec_units     (sec_units),
        .running       (running),
        .done          (done),
        .done_pulse    (done_pulse),
        .load_err      (load_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic do_load(input logic [3:0] mt, input logic [3:0] mu,
                           input logic [3:0] st, input logic [3:0] su);
        set_min_tens = mt; set_min_units = mu;
        set_sec_tens = st; set_sec_units = su;
        load = 1'b1;
        @(negedge clock);
        load = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic do_pause();
        pause = 1'b1;
        @(negedge clock);
        pause = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(negedge clock);
        clear = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        load = 1'b0; start = 1'b0; pause = 1'b0; clear = 1'b0;
        set_min_tens = '0; set_min_units = '0; set_sec_tens = '0; set_sec_units = '0;
        cyc(2);
        checks++;
        if ({digits, running, done, done_pulse, load_err} !== 20'h0) begin
            failures++;
            $display("FAIL reset_state got=%h exp=%h", {digits, running, done, done_pulse, load_err}, 20'h0);
        end
        reset_n = 1'b1;
        cyc(1);
        checks++;
        if ({digits, running, done} !== 18'h0) begin
            failures++;
            $display("FAIL after_reset got=%h exp=%h", {digits, running, done}, 18'h0);
        end
    endtask

    task automatic test_countdown();
        do_load(4'd0, 4'd0, 4'd0, 4'd3);
        checks++;
        if ({digits, running} !== {16'h0003, 1'b0}) begin
            failures++;
            $display("FAIL cd_load got=%h exp=%h", {digits, running}, {16'h0003, 1'b0});
        end
        do_start();
        cyc(3);
        checks++;
        if ({digits, running} !== {16'h0003, 1'b1}) begin
            failures++;
            $display("FAIL cd_plus3 got=%h exp=%h", {digits, running}, {16'h0003, 1'b1});
        end
        cyc(1);
        checks++;
        if (digits !== 16'h0002) begin
            failures++;
            $display("FAIL cd_plus4 got=%h exp=%h", digits, 16'h0002);
        end
        cyc(4);
        checks++;
        if (digits !== 16'h0001) begin
            failures++;
            $display("FAIL cd_plus8 got=%h exp=%h", digits, 16'h0001);
        end
        cyc(3);
        checks++;
        if ({digits, done, done_pulse} !== {16'h0001, 2'b00}) begin
            failures++;
            $display("FAIL cd_plus11 got=%h exp=%h", {digits, done, done_pulse}, {16'h0001, 2'b00});
        end
        cyc(1);
        checks++;
        if ({digits, running, done, done_pulse} !== {16'h0000, 3'b011}) begin
            failures++;
            $display("FAIL cd_plus12 got=%h exp=%h", {digits, running, done, done_pulse}, {16'h0000, 3'b011});
        end
        cyc(1);
        checks++;
        if ({digits, running, done, done_pulse} !== {16'h0000, 3'b010}) begin
            failures++;
            $display("FAIL cd_plus13 got=%h exp=%h", {digits, running, done, done_pulse}, {16'h0000, 3'b010});
        end
        cyc(4);
        checks++;
        if ({digits, done} !== {16'h0000, 1'b1}) begin
            failures++;
            $display("FAIL cd_done_hold got=%h exp=%h", {digits, done}, {16'h0000, 1'b1});
        end
    endtask

    task automatic test_borrow();
        do_load(4'd0, 4'd1, 4'd0, 4'd0);
        checks++;
        if ({digits, done} !== {16'h0100, 1'b0}) begin
            failures++;
            $display("FAIL br_load got=%h exp=%h", {digits, done}, {16'h0100, 1'b0});
        end
        do_start();
        cyc(4);
        checks++;
        if (digits !== 16'h0059) begin
            failures++;
            $display("FAIL br_borrow got=%h exp=%h", digits, 16'h0059);
        end
        do_clear();
        do_load(4'd9, 4'd9, 4'd5, 4'd9);
        checks++;
        if ({digits, load_err} !== {16'h9959, 1'b0}) begin
            failures++;
            $display("FAIL br_max got=%h exp=%h", {digits, load_err}, {16'h9959, 1'b0});
        end
    endtask

    task automatic test_load_err();
        do_load(4'd1, 4'd2, 4'd6, 4'd0);
        checks++;
        if ({digits, load_err, running} !== {16'h9959, 2'b10}) begin
            failures++;
            $display("FAIL le_sec_tens got=%h exp=%h", {digits, load_err, running}, {16'h9959, 2'b10});
        end
        cyc(1);
        checks++;
        if (load_err !== 1'b0) begin
            failures++;
            $display("FAIL le_one_cycle got=%b exp=%b", load_err, 1'b0);
        end
        do_load(4'd0, 4'hA, 4'd0, 4'd1);
        checks++;
        if ({digits, load_err} !== {16'h9959, 1'b1}) begin
            failures++;
            $display("FAIL le_min_units got=%h exp=%h", {digits, load_err}, {16'h9959, 1'b1});
        end
        cyc(1);
        checks++;
        if (load_err !== 1'b0) begin
            failures++;
            $display("FAIL le_one_cycle2 got=%b exp=%b", load_err, 1'b0);
        end
        // Still READY: start must take effect.
        do_start();
        checks++;
        if (running !== 1'b1) begin
            failures++;
            $display("FAIL le_still_ready got=%b exp=%b", running, 1'b1);
        end
        do_clear();
        checks++;
        if ({digits, running} !== {16'h0000, 1'b0}) begin
            failures++;
            $display("FAIL le_clear got=%h exp=%h", {digits, running}, {16'h0000, 1'b0});
        end
    endtask

    task automatic test_pause_resume();
        do_load(4'd0, 4'd0, 4'd0, 4'd5);
        do_start();
        cyc(6);
        do_pause();
        checks++;
        if ({digits, running} !== {16'h0004, 1'b0}) begin
            failures++;
            $display("FAIL pr_paused got=%h exp=%h", {digits, running}, {16'h0004, 1'b0});
        end
        cyc(20);
        checks++;
        if ({digits, running} !== {16'h0004, 1'b0}) begin
            failures++;
            $display("FAIL pr_frozen got=%h exp=%h", {digits, running}, {16'h0004, 1'b0});
        end
        do_start();
        checks++;
        if ({digits, running} !== {16'h0004, 1'b1}) begin
            failures++;
            $display("FAIL pr_resume got=%h exp=%h", {digits, running}, {16'h0004, 1'b1});
        end
        cyc(1);
        checks++;
        if (digits !== 16'h0004) begin
            failures++;
            $display("FAIL pr_resume1 got=%h exp=%h", digits, 16'h0004);
        end
        cyc(1);
        checks++;
        if (digits !== 16'h0003) begin
            failures++;
            $display("FAIL pr_resume2 got=%h exp=%h", digits, 16'h0003);
        end
    endtask

    task automatic test_running_cmds();
        // Continues from 00:03 with the prescaler just wrapped to 0.
        do_load(4'd0, 4'd0, 4'd0, 4'd9);
        checks++;
        if ({digits, running, load_err} !== {16'h0003, 2'b10}) begin
            failures++;
            $display("FAIL rc_load_ignored got=%h exp=%h", {digits, running, load_err}, {16'h0003, 2'b10});
        end
        cyc(2);
        checks++;
        if (digits !== 16'h0003) begin
            failures++;
            $display("FAIL rc_before_tick got=%h exp=%h", digits, 16'h0003);
        end
        // This clear lands on the tick edge.
        do_clear();
        checks++;
        if ({digits, running, done, done_pulse} !== {16'h0000, 3'b000}) begin
            failures++;
            $display("FAIL rc_clear_tick got=%h exp=%h", {digits, running, done, done_pulse}, {16'h0000, 3'b000});
        end
        do_start();
        cyc(5);
        checks++;
        if ({digits, running, done} !== {16'h0000, 2'b00}) begin
            failures++;
            $display("FAIL rc_idle_start got=%h exp=%h", {digits, running, done}, {16'h0000, 2'b00});
        end
    endtask

    task automatic test_async_reset();
        do_load(4'd0, 4'd0, 4'd0, 4'd5);
        do_start();
        cyc(5);
        checks++;
        if ({digits, running} !== {16'h0004, 1'b1}) begin
            failures++;
            $display("FAIL ar_pre got=%h exp=%h", {digits, running}, {16'h0004, 1'b1});
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({digits, running, done, done_pulse, load_err} !== 20'h0) begin
            failures++;
            $display("FAIL ar_immediate got=%h exp=%h", {digits, running, done, done_pulse, load_err}, 20'h0);
        end
        cyc(2);
        reset_n = 1'b1;
        cyc(1);
        do_load(4'd0, 4'd0, 4'd0, 4'd0);
        checks++;
        if ({digits, running, done, load_err} !== {16'h0000, 3'b000}) begin
            failures++;
            $display("FAIL ar_load_zero got=%h exp=%h", {digits, running, done, load_err}, {16'h0000, 3'b000});
        end
        do_start();
        cyc(8);
        checks++;
        if ({digits, running, done, done_pulse} !== {16'h0000, 3'b000}) begin
            failures++;
            $display("FAIL ar_zero_start got=%h exp=%h", {digits, running, done, done_pulse}, {16'h0000, 3'b000});
        end
    endtask

    initial begin
        test_reset();
        test_countdown();
        test_borrow();
        test_load_err();
        test_pause_resume();
        test_running_cmds();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
